riscv_top: RTL and testbench

Self-contained processor top: a minimal single-cycle RV32I-subset scalar core with private instruction and data memories, plus an external word-write port for loading memories. It is the simulation root of the processor subsystem. It has no functional outputs; results are observed through the memory and register-file hierarchy. Memories may also be preloaded by `$readmemh` on the hierarchical paths given below.

---
 rtl/riscv_top.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_riscv_top.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_top.sv
// Minimal single-cycle RV32I-subset core with private instruction/data memories
// and an external word-write port that loads both memories.

module rv_mem #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  i_ext_we,
  input  logic [ADDR_WIDTH-1:0] i_ext_addr,
  input  logic [WIDTH-1:0]      i_ext_data,
  input  logic                  i_core_we,
  input  logic [ADDR_WIDTH-1:0] i_core_addr,
  input  logic [WIDTH-1:0]      i_core_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);
  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  // External write is issued last so it overrides a core store to the same word.
  always_ff @(posedge clk) begin
    if (i_core_we) mem[i_core_addr] <= i_core_data;
    if (i_ext_we)  mem[i_ext_addr]  <= i_ext_data;
  end

  assign o_rd_data = mem[i_rd_addr];
endmodule

module rv_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  output logic [31:0] o_rs1,
  output logic [31:0] o_rs2
);
  logic [31:0] rf [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (i_we && (i_rd != 5'd0)) begin
      rf[i_rd] <= i_wdata;
    end
  end

  assign o_rs1 = (i_rs1 == 5'd0) ? 32'd0 : rf[i_rs1];
  assign o_rs2 = (i_rs2 == 5'd0) ? 32'd0 : rf[i_rs2];
endmodule

module rv_scalar_proc #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_wr,
  input  logic [WIDTH-1:0]      data_in
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [31:0]           r_pc;
  logic [31:0]           w_instr;
  logic [6:0]            w_opcode;
  logic [4:0]            w_rd;
  logic [2:0]            w_funct3;
  logic [4:0]            w_rs1_idx;
  logic [4:0]            w_rs2_idx;
  logic [6:0]            w_funct7;
  logic [31:0]           w_imm_i;
  logic [31:0]           w_imm_s;
  logic [31:0]           w_imm_b;
  logic [31:0]           w_imm_u;
  logic [31:0]           w_imm_j;
  logic [31:0]           w_imm_ls;
  logic [31:0]           w_rs1;
  logic [31:0]           w_rs2;
  logic [31:0]           w_pc_plus4;
  logic [ADDR_WIDTH-1:0] w_dm_idx;
  logic [31:0]           w_dm_rdata;
  logic                  w_lt;
  logic                  w_ltu;
  logic                  w_rf_we;
  logic [31:0]           w_wb;
  logic                  w_dm_we;
  logic [31:0]           w_next_pc;

  assign w_opcode  = w_instr[6:0];
  assign w_rd      = w_instr[11:7];
  assign w_funct3  = w_instr[14:12];
  assign w_rs1_idx = w_instr[19:15];
  assign w_rs2_idx = w_instr[24:20];
  assign w_funct7  = w_instr[31:25];

  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'd0};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

  // Stores are the only memory opcode with bit 5 set; the index drops the
  // byte offset and any bits above the memory size.
  assign w_imm_ls   = w_opcode[5] ? w_imm_s : w_imm_i;
  assign w_dm_idx   = ADDR_WIDTH'((w_rs1 + w_imm_ls) >> 2);
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_lt       = $signed(w_rs1) < $signed(w_rs2);
  assign w_ltu      = w_rs1 < w_rs2;

  rv_mem #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) instructionmemory (
    .clk         (clk),
    .i_ext_we    (we),
    .i_ext_addr  (addr_wr),
    .i_ext_data  (data_in),
    .i_core_we   (1'b0),
    .i_core_addr ('0),
    .i_core_data ('0),
    .i_rd_addr   (r_pc[ADDR_WIDTH+1:2]),
    .o_rd_data   (w_instr)
  );

  rv_mem #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) Datamemory (
    .clk         (clk),
    .i_ext_we    (we),
    .i_ext_addr  (addr_wr),
    .i_ext_data  (data_in),
    .i_core_we   (w_dm_we & ~rst),
    .i_core_addr (w_dm_idx),
    .i_core_data (w_rs2),
    .i_rd_addr   (w_dm_idx),
    .o_rd_data   (w_dm_rdata)
  );

  rv_regfile regfile (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_rf_we),
    .i_rd    (w_rd),
    .i_wdata (w_wb),
    .i_rs1   (w_rs1_idx),
    .i_rs2   (w_rs2_idx),
    .o_rs1   (w_rs1),
    .o_rs2   (w_rs2)
  );

  // Anything not decoded below falls through as a NOP.
  always_comb begin
    w_rf_we   = 1'b0;
    w_wb      = '0;
    w_dm_we   = 1'b0;
    w_next_pc = w_pc_plus4;
    case (w_opcode)
      OP_LUI: begin
        w_rf_we = 1'b1;
        w_wb    = w_imm_u;
      end
      OP_AUIPC: begin
        w_rf_we = 1'b1;
        w_wb    = r_pc + w_imm_u;
      end
      OP_IMM: begin
        case (w_funct3)
          3'b000: begin w_rf_we = 1'b1; w_wb = w_rs1 + w_imm_i; end
          3'b111: begin w_rf_we = 1'b1; w_wb = w_rs1 & w_imm_i; end
          3'b110: begin w_rf_we = 1'b1; w_wb = w_rs1 | w_imm_i; end
          3'b100: begin w_rf_we = 1'b1; w_wb = w_rs1 ^ w_imm_i; end
          3'b010: begin
            w_rf_we = 1'b1;
            w_wb    = {31'd0, $signed(w_rs1) < $signed(w_imm_i)};
          end
          3'b001: begin
            if (w_funct7 == F7_ZERO) begin
              w_rf_we = 1'b1;
              w_wb    = w_rs1 << w_rs2_idx;
            end
          end
          3'b101: begin
            if (w_funct7 == F7_ZERO) begin
              w_rf_we = 1'b1;
              w_wb    = w_rs1 >> w_rs2_idx;
            end else if (w_funct7 == F7_ALT) begin
              w_rf_we = 1'b1;
              w_wb    = $unsigned($signed(w_rs1) >>> w_rs2_idx);
            end
          end
          default: ;
        endcase
      end
      OP_REG: begin
        if (w_funct7 == F7_ZERO) begin
          w_rf_we = 1'b1;
          case (w_funct3)
            3'b000:  w_wb = w_rs1 + w_rs2;
            3'b111:  w_wb = w_rs1 & w_rs2;
            3'b110:  w_wb = w_rs1 | w_rs2;
            3'b100:  w_wb = w_rs1 ^ w_rs2;
            3'b010:  w_wb = {31'd0, w_lt};
            3'b011:  w_wb = {31'd0, w_ltu};
            3'b001:  w_wb = w_rs1 << w_rs2[4:0];
            default: w_wb = w_rs1 >> w_rs2[4:0];
          endcase
        end else if (w_funct7 == F7_ALT) begin
          if (w_funct3 == 3'b000) begin
            w_rf_we = 1'b1;
            w_wb    = w_rs1 - w_rs2;
          end else if (w_funct3 == 3'b101) begin
            w_rf_we = 1'b1;
            w_wb    = $unsigned($signed(w_rs1) >>> w_rs2[4:0]);
          end
        end
      end
      OP_LOAD: begin
        if (w_funct3 == 3'b010) begin
          w_rf_we = 1'b1;
          w_wb    = w_dm_rdata;
        end
      end
      OP_STORE: begin
        if (w_funct3 == 3'b010) w_dm_we = 1'b1;
      end
      OP_BRANCH: begin
        case (w_funct3)
          3'b000:  if (w_rs1 == w_rs2) w_next_pc = r_pc + w_imm_b;
          3'b001:  if (w_rs1 != w_rs2) w_next_pc = r_pc + w_imm_b;
          3'b100:  if (w_lt)           w_next_pc = r_pc + w_imm_b;
          3'b101:  if (!w_lt)          w_next_pc = r_pc + w_imm_b;
          default: ;
        endcase
      end
      OP_JAL: begin
        w_rf_we   = 1'b1;
        w_wb      = w_pc_plus4;
        w_next_pc = r_pc + w_imm_j;
      end
      OP_JALR: begin
        if (w_funct3 == 3'b000) begin
          w_rf_we   = 1'b1;
          w_wb      = w_pc_plus4;
          w_next_pc = (w_rs1 + w_imm_i) & ~32'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_pc <= '0;
    else     r_pc <= w_next_pc;
  end
endmodule

module riscv_top #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_wr,
  input  logic [WIDTH-1:0]      data_in
);
  rv_scalar_proc #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) scalar_proc (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .addr_wr (addr_wr),
    .data_in (data_in)
  );
endmodule

// File: tb/tb_riscv_top.sv
// Directed program bench: stimulus loads programs and queues expected state,
// a monitor process compares queued expectations against the core hierarchy.

module tb_riscv_top;
  localparam int AW = 15;
  localparam int P_PC = 0, P_RF = 1, P_DM = 2, P_IM = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic [AW-1:0] addr_wr = '0;
  logic [31:0]   data_in = '0;

  typedef struct {
    string       name;
    int          sel;
    int          idx;
    logic [31:0] expv;
  } chk_t;

  chk_t        sbq[$];
  logic [31:0] prog[$];
  int          total = 0;
  int          bad = 0;

  riscv_top #(.WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .addr_wr (addr_wr),
    .data_in (data_in)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Monitor: state is stable between the falling edge and the next rising edge.
  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      #1;
      while (sbq.size() > 0) begin
        c = sbq.pop_front();
        case (c.sel)
          P_PC:    act = dut.scalar_proc.r_pc;
          P_RF:    act = dut.scalar_proc.regfile.rf[c.idx];
          P_DM:    act = dut.scalar_proc.Datamemory.mem[c.idx];
          default: act = dut.scalar_proc.instructionmemory.mem[c.idx];
        endcase
        total++;
        if (act !== c.expv) begin
          bad++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.expv);
        end
      end
    end
  end

  task automatic expect_v(input string name, input int sel, input int idx, input logic [31:0] v);
    sbq.push_back('{name: name, sel: sel, idx: idx, expv: v});
  endtask

  task automatic drain();
    #2;
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  // Loads prog[] through the external port while reset is held.
  task automatic load();
    @(negedge clk);
    rst = 1'b1;
    foreach (prog[i]) begin
      we = 1'b1;
      addr_wr = AW'(i);
      data_in = prog[i];
      @(negedge clk);
    end
    we = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);

    // ALU
    prog = '{32'h00500093, 32'hFFD00113, 32'h002081B3, 32'h40110233, 32'h0000006F};
    load();
    expect_v("alu_reset_pc", P_PC, 0, 32'h0);
    drain();
    rst = 1'b0;
    run(1);
    expect_v("alu_first_x1", P_RF, 1, 32'd5);
    expect_v("alu_first_pc", P_PC, 0, 32'h4);
    drain();
    run(4);
    expect_v("alu_x2", P_RF, 2, 32'hFFFFFFFD);
    expect_v("alu_x3", P_RF, 3, 32'd2);
    expect_v("alu_x4", P_RF, 4, 32'hFFFFFFF8);
    expect_v("alu_pc", P_PC, 0, 32'h10);
    drain();
    run(3);
    expect_v("alu_halt_pc", P_PC, 0, 32'h10);
    drain();

    // Load/store, misaligned offset and aliased upper address bits
    prog = '{32'h123450B7, 32'h67808093, 32'h04102023, 32'h04002283,
             32'h04302303, 32'h000203B7, 32'h0403A403, 32'h0000006F};
    load();
    expect_v("rst_pc", P_PC, 0, 32'h0);
    expect_v("rst_x1", P_RF, 1, 32'h0);
    expect_v("rst_x3", P_RF, 3, 32'h0);
    expect_v("rst_x4", P_RF, 4, 32'h0);
    drain();
    rst = 1'b0;
    run(8);
    expect_v("ls_x1", P_RF, 1, 32'h12345678);
    expect_v("ls_dm16", P_DM, 16, 32'h12345678);
    expect_v("ls_x5", P_RF, 5, 32'h12345678);
    expect_v("ls_misalign_x6", P_RF, 6, 32'h12345678);
    expect_v("ls_alias_x8", P_RF, 8, 32'h12345678);
    expect_v("ls_pc", P_PC, 0, 32'h1C);
    drain();

    // Branch loop
    prog = '{32'h00000093, 32'h00A00113, 32'h00108093, 32'hFE209EE3, 32'h0000006F};
    load();
    rst = 1'b0;
    run(21);
    expect_v("br_last_bne_pc", P_PC, 0, 32'hC);
    expect_v("br_x1_early", P_RF, 1, 32'd10);
    drain();
    run(1);
    expect_v("br_fall_pc", P_PC, 0, 32'h10);
    expect_v("br_x1", P_RF, 1, 32'd10);
    drain();

    // JAL / JALR
    prog = '{32'h008000EF, 32'h0000006F, 32'h00008067};
    load();
    rst = 1'b0;
    run(1);
    expect_v("jal_x1", P_RF, 1, 32'h4);
    expect_v("jal_pc", P_PC, 0, 32'h8);
    drain();
    run(1);
    expect_v("jalr_pc", P_PC, 0, 32'h4);
    drain();
    run(2);
    expect_v("jalr_loop_pc", P_PC, 0, 32'h4);
    drain();

    // External write, unsupported opcode, write to x0
    prog = '{32'h00700093, 32'h00000057, 32'h00500013, 32'h0000006F};
    load();
    expect_v("ext_im0", P_IM, 0, 32'h00700093);
    expect_v("ext_dm0", P_DM, 0, 32'h00700093);
    drain();
    rst = 1'b0;
    run(1);
    expect_v("ext_x1", P_RF, 1, 32'd7);
    drain();
    run(1);
    expect_v("nop_pc", P_PC, 0, 32'h8);
    expect_v("nop_x1", P_RF, 1, 32'd7);
    drain();
    run(1);
    expect_v("x0_discard", P_RF, 0, 32'h0);
    expect_v("x0_pc", P_PC, 0, 32'hC);
    drain();

    // Store vs external write collision, then mid-program reset
    prog = '{32'h05500093, 32'h04102023, 32'h0000006F};
    load();
    rst = 1'b0;
    run(1);
    we = 1'b1;
    addr_wr = AW'(16);
    data_in = 32'hCAFEF00D;
    run(1);
    we = 1'b0;
    expect_v("coll_dm16", P_DM, 16, 32'hCAFEF00D);
    expect_v("coll_im16", P_IM, 16, 32'hCAFEF00D);
    expect_v("coll_pc", P_PC, 0, 32'h8);
    drain();
    rst = 1'b1;
    run(1);
    expect_v("mid_rst_pc", P_PC, 0, 32'h0);
    expect_v("mid_rst_x1", P_RF, 1, 32'h0);
    expect_v("mid_rst_dm16", P_DM, 16, 32'hCAFEF00D);
    drain();
    rst = 1'b0;
    run(2);
    expect_v("restart_dm16", P_DM, 16, 32'h00000055);
    expect_v("restart_pc", P_PC, 0, 32'h8);
    drain();

    // Signed branch, SLTU, SRLI/SRAI
    prog = '{32'hFFF00093, 32'h0000C463, 32'h00100193, 32'h001032B3,
             32'h0040D313, 32'h4040D393, 32'h0000006F};
    load();
    rst = 1'b0;
    run(6);
    expect_v("blt_skip_x3", P_RF, 3, 32'h0);
    expect_v("sltu_x5", P_RF, 5, 32'd1);
    expect_v("srli_x6", P_RF, 6, 32'h0FFFFFFF);
    expect_v("srai_x7", P_RF, 7, 32'hFFFFFFFF);
    expect_v("misc_pc", P_PC, 0, 32'h18);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
